// File: rtl/serial_shift_engine.sv
// Self-sequencing bit-serial shifter: loads an operand on start, emits up to LIMIT bits in the
// chosen order and counts bits and ones. Define SERIAL_EARLY_EXIT_EN to stop once Q holds no 1s.
module serial_shift_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = WIDTH,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             msb_first_i,
  output logic             busy_o,
  output logic             ser_valid_o,
  output logic             ser_out_o,
  output logic             done_o,
  output logic [CW-1:0]    ones_o,
  output logic [CW-1:0]    bits_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             order_q, order_d;
  logic [CW-1:0]    bits_q, bits_d;
  logic [CW-1:0]    ones_q, ones_d;

  logic             ser_bit;
  logic [WIDTH-1:0] q_shift;
  logic [CW-1:0]    bits_inc;
  logic             exhausted;

  assign ser_bit  = order_q ? q_q[WIDTH-1] : q_q[0];
  assign q_shift  = order_q ? {q_q[WIDTH-2:0], 1'b0} : {1'b0, q_q[WIDTH-1:1]};
  assign bits_inc = bits_q + CW'(1);

`ifdef SERIAL_EARLY_EXIT_EN
  // Nothing left to emit but zeros: finish on the bit just shifted out.
  assign exhausted = (q_shift == '0);
`else
  assign exhausted = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    order_d = order_q;
    bits_d  = bits_q;
    ones_d  = ones_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          q_d     = din_i;
          order_d = msb_first_i;
          bits_d  = '0;
          ones_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        q_d    = q_shift;
        bits_d = bits_inc;
        ones_d = ones_q + CW'(ser_bit);
        if (bits_inc == CW'(LIMIT) || exhausted) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      order_q <= 1'b0;
      bits_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      order_q <= order_d;
      bits_q  <= bits_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    busy_o      = (state_q != StIdle);
    ser_valid_o = (state_q == StShift);
    ser_out_o   = ser_valid_o & ser_bit;
    done_o      = (state_q == StDone);
    ones_o      = ones_q;
    bits_o      = bits_q;
  end

endmodule

// File: doc/serial_shift_engine.md
# serial_shift_engine

Parametrised bit-serial datapath and control unit. It loads a WIDTH-bit operand on `start` and shifts it out one bit per cycle, LSB-first or MSB-first, while counting emitted bits and ones. It stops after LIMIT bits, or optionally as soon as the remaining operand is zero. It is the self-sequencing successor to the fixed 8-bit shift/count datapath: FSM, handshake and result registers live inside the block, so the parent only drives `start` and consumes `done`.

## Interface
- `WIDTH`, default 8: operand width, ≥2.
- `LIMIT`, default WIDTH: maximum bits emitted per operation, 1..WIDTH.
- `CW` (localparam) = $clog2(WIDTH+1): width of the counters.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; accepted only in IDLE.
- `din`  in  WIDTH  operand, sampled on accepted start.
- `msb_first`  in  1  bit order, sampled on accepted start: 0 = LSB first, 1 = MSB first.
- `busy`  out  1  high whenever state ≠ IDLE.
- `ser_valid`  out  1  high in each cycle a bit is emitted.
- `ser_out`  out  1  emitted bit; 0 when `ser_valid`=0.
- `done`  out  1  one-cycle completion pulse.
- `ones`  out  CW  count of 1 bits emitted in the last or current operation.
- `bits`  out  CW  count of bits emitted in the last or current operation.

## Operation
- Registers:
  - shift register Q[WIDTH-1:0]
  - latched order bit
  - `bits` and `ones` counters (CW bits each)
  - 2-bit FSM state: IDLE, SHIFT, DONE
- IDLE:
  - `start`=1 → Q←din, order←msb_first, bits←0, ones←0, go to SHIFT.
  - `start`=0 → hold. Q, `bits` and `ones` keep their last values.
- SHIFT, every cycle:
  - `ser_valid`=1.
  - `ser_out` = Q[0] when LSB first, Q[WIDTH-1] when MSB first.
  - Q ← Q>>1 (LSB first) or Q<<1 (MSB first), zero-filled.
  - bits ← bits+1; ones ← ones+`ser_out`.
  - Go to DONE when bits+1 == LIMIT. Optionally also exit early; see Configuration.
  - At least one bit is always emitted.
- DONE: `done`=1 for exactly one cycle, then IDLE. `ser_valid`=0.
- `start` while `busy`=1 (including the DONE cycle) is ignored, with no queuing.
- `din` and `msb_first` are don't-care except in the accepting cycle.
- `ser_out`, `ser_valid`, `busy` and `done` are decoded combinationally from state and Q only, never from inputs.
- Counters never wrap: `bits` ≤ LIMIT ≤ WIDTH < 2^CW.

## Timing
- Reset (asynchronous): state=IDLE, Q=0, order=0, `bits`=0, `ones`=0. All outputs read 0.
- `start` accepted at edge 0 → first bit valid in cycle 1, bit k valid in cycle k.
- Without early exit: last bit in cycle LIMIT, `done` in cycle LIMIT+1, `busy` falls in cycle LIMIT+2.
- Earliest next acceptance is the cycle after `done`. Back-to-back period is LIMIT+2 cycles.
- `ones` and `bits` are final in the `done` cycle and hold until the next accepted `start`.
- `rst` during SHIFT or DONE aborts immediately with no `done` pulse. The next `start` after release operates normally.

## Configuration
- `SERIAL_EARLY_EXIT_EN` defined:
  - SHIFT also goes to DONE when the post-shift value of Q is 0, i.e. no 1 bits remain.
  - The last emitted bit is therefore the final 1 in the chosen order.
  - din=0 emits a single 0 bit with bits=1.
  - `ones` is identical to the non-early result. `bits` reports the bits actually emitted.
- Not defined: every operation emits exactly LIMIT bits. Q==0 has no effect on sequencing.

## Test plan
- WIDTH=8, LIMIT=8, din=0xB4, msb_first=0, no macro → `ser_out` 0,0,1,0,1,1,0,1 in cycles 1–8; `done` in cycle 9; ones=4, bits=8.
- Same operand with msb_first=1 → 1,0,1,1,0,1,0,0; ones=4, bits=8, `done` in cycle 9.
- din=0x0C, LSB first:
  - with `SERIAL_EARLY_EXIT_EN` → 0,0,1,1 in cycles 1–4; `done` in cycle 5; bits=4, ones=2.
  - without the macro → 8 bits, `done` in cycle 9.
- LIMIT=5, din=0xFF → five 1s in cycles 1–5; `done` in cycle 6; ones=5, bits=5. Upper bits are never emitted.
- `start` pulsed in cycles 3 and 9 (the DONE cycle) during an operation → both ignored, result unchanged. `start` in cycle 10 is accepted.
- `rst` asserted in cycle 4 of an operation → all outputs 0 at once, no `done`. After release, din=0x01 runs normally with ones=1 and `done` at the expected cycle.
